// File: rtl/amiga_pkg.sv
// amiga_pkg: shared FSM states and phase-decode windows for the A1000 clock/reset generator
package amiga_pkg;
  typedef enum logic [1:0] {POR, HOLD, RUN} state_e;
  localparam logic [3:0] C7M_HI  = 4'b0011;
  localparam logic [3:0] CDAC_HI = 4'b0110;
  localparam logic [7:0] C1_HI   = 8'hF0;
  localparam logic [7:0] C3_HI   = 8'hC3;
endpackage

// File: rtl/amiga_reset_debounce.sv
// amiga_reset_debounce: synchronizes _RST_IN and flags a sustained low level
module amiga_reset_debounce #(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic mask,
  input  logic _RST_IN,
  output logic hit
);
  localparam int LW = $clog2(DEBOUNCE + 1);
  localparam logic [LW-1:0] LO_MAX = LW'(DEBOUNCE);
  logic [1:0] sync_q, sync_d;
  logic [LW-1:0] lo_cnt_q, lo_cnt_d;
  always_comb begin
    sync_d = {sync_q[0], _RST_IN};
    lo_cnt_d = (mask || sync_q[1]) ? '0 : (lo_cnt_q == LO_MAX ? lo_cnt_q : lo_cnt_q + 1'b1);
    hit = lo_cnt_q == LO_MAX;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      lo_cnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      lo_cnt_q <= lo_cnt_d;
    end
  end
endmodule

// File: rtl/amiga_clock_reset_gen.sv
// amiga_clock_reset_gen: A1000 phase clocks from 28 MHz and _RST pull-down sequencing
module amiga_clock_reset_gen
  import amiga_pkg::*;
#(
  parameter int RESET_HOLD = 16,
  parameter int DEBOUNCE = 8
) (
  input  logic CLK_28M,
  input  logic RST,
  input  logic _RST_IN,
  input  logic KBRST,
  output logic C7M,
  output logic CDAC,
  output logic _C1,
  output logic _C3,
  output logic _RST_OE,
  output logic RESET_DONE
);
  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD);
  logic [2:0] p_q, p_d;
  logic [3:0] clk_q, clk_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  state_e state_q, state_d;
  logic rst_oe_q, rst_oe_d, done_q, done_d, hit;
  amiga_reset_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk(CLK_28M),
    .rst(RST),
    .mask(rst_oe_q),
    ._RST_IN(_RST_IN),
    .hit(hit)
  );
  // Decode from p_d so each registered clock matches the phase p_q holds.
  always_comb begin
    p_d = p_q + 3'd1;
    clk_d = {C7M_HI[p_d[1:0]], CDAC_HI[p_d[1:0]], C1_HI[p_d], C3_HI[p_d]};
    hold_inc = hold_cnt_q + HW'(p_q == 3'd7);
    state_d = state_q;
    hold_cnt_d = hold_cnt_q;
    if (state_q == POR) begin
      state_d = HOLD;
    end else if (KBRST || (state_q == RUN && hit)) begin
      state_d = HOLD;
      hold_cnt_d = '0;
    end else if (state_q == HOLD) begin
      state_d = hold_inc == HOLD_MAX ? RUN : HOLD;
      hold_cnt_d = hold_inc == HOLD_MAX ? '0 : hold_inc;
    end
    rst_oe_d = state_d != RUN;
    done_d = state_d == RUN;
  end
  always_ff @(posedge CLK_28M) begin
    if (RST) begin
      p_q <= '0;
      clk_q <= 4'b1001;
      hold_cnt_q <= '0;
      state_q <= POR;
      rst_oe_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      p_q <= p_d;
      clk_q <= clk_d;
      hold_cnt_q <= hold_cnt_d;
      state_q <= state_d;
      rst_oe_q <= rst_oe_d;
      done_q <= done_d;
    end
  end
  assign {C7M, CDAC, _C1, _C3} = clk_q;
  assign _RST_OE = rst_oe_q;
  assign RESET_DONE = done_q;
endmodule
